// File: rtl/neuron_layer_sched.sv
// =============================================================================
// Module      : neuron_layer_sched
// Description : Issues neuron indices to a shared Q8.24 neuron datapath, tracks
//               its latency and tags each returning activation with its index.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module neuron_layer_sched #(
    parameter int WIDTH    = 32,
    parameter int N_NEURON = 4,
    parameter int IDX_W    = 2,
    parameter int LAT      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] a_1,
    input  logic [WIDTH-1:0] a_2,
    input  logic [WIDTH-1:0] a_3,
    output logic [WIDTH-1:0] n_a_1,
    output logic [WIDTH-1:0] n_a_2,
    output logic [WIDTH-1:0] n_a_3,
    output logic [IDX_W-1:0] wb_addr,
    output logic             n_en,
    input  logic [WIDTH-1:0] n_y,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W:0] C_LAST_IDX = (IDX_W + 1)'(N_NEURON - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [IDX_W:0]   r_issue_cnt;
    logic [WIDTH-1:0] r_n_a_1;
    logic [WIDTH-1:0] r_n_a_2;
    logic [WIDTH-1:0] r_n_a_3;
    logic             r_busy;
    logic             r_done;
    logic [LAT-1:0]   r_vld;
    logic [IDX_W-1:0] r_idx [LAT];

    logic             w_issuing;
    logic [IDX_W-1:0] w_wb_addr;
    logic             w_mid_busy;

    assign w_issuing = (r_state == ST_ISSUE);
    assign w_wb_addr = w_issuing ? r_issue_cnt[IDX_W-1:0] : '0;

    // The tail stage drains on the same edge that DRAIN is left, so only the
    // stages ahead of it decide whether the pipe will be empty after this edge.
    generate
        if (LAT > 1) begin : g_mid
            assign w_mid_busy = |r_vld[LAT-2:0];
        end else begin : g_nomid
            assign w_mid_busy = 1'b0;
        end
    endgenerate

    // Valid/index shadow pipe: mirrors the datapath latency, frozen by en.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_idx[i] <= '0;
            end
        end else if (en) begin
            r_vld[0] <= w_issuing;
            r_idx[0] <= w_wb_addr;
            for (int i = LAT - 1; i > 0; i--) begin
                r_vld[i] <= r_vld[i-1];
                r_idx[i] <= r_idx[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_issue_cnt <= '0;
            r_n_a_1     <= '0;
            r_n_a_2     <= '0;
            r_n_a_3     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (en) begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_n_a_1     <= a_1;
                        r_n_a_2     <= a_2;
                        r_n_a_3     <= a_3;
                        r_busy      <= 1'b1;
                        r_issue_cnt <= '0;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Counter is one bit wider than the index so a full
                    // 2**IDX_W layer terminates without wrapping.
                    r_issue_cnt <= r_issue_cnt + 1'b1;
                    if (r_issue_cnt == C_LAST_IDX) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!w_mid_busy) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign n_a_1     = r_n_a_1;
    assign n_a_2     = r_n_a_2;
    assign n_a_3     = r_n_a_3;
    assign wb_addr   = w_wb_addr;
    assign n_en      = en & (r_state != ST_IDLE);
    // Gating with en keeps a stalled tail result from being reported twice.
    assign out_valid = en & r_vld[LAT-1];
    assign out_idx   = r_idx[LAT-1];
    assign out_data  = n_y;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_neuron_layer_sched.sv
// =============================================================================
// Module      : tb_neuron_layer_sched
// Description : Directed self-checking bench for neuron_layer_sched with an
//               en-gated delay-line model of the neuron datapath.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_neuron_layer_sched;

    localparam int WIDTH = 32;
    localparam logic [31:0] C_A1 = 32'h0100_0000;
    localparam logic [31:0] C_A2 = 32'h0080_0000;
    localparam logic [31:0] C_A3 = 32'hFF00_0000;
    localparam logic [31:0] C_Y0 = 32'h0010_0000;

    logic             clk = 1'b0;
    logic             rst, en, start, start2;
    logic [WIDTH-1:0] a_1, a_2, a_3;

    logic [WIDTH-1:0] n_a_1, n_a_2, n_a_3, n_y, out_data;
    logic [1:0]       wb_addr, out_idx;
    logic             n_en, out_valid, busy, done;

    logic [WIDTH-1:0] n2_a_1, n2_a_2, n2_a_3, n_y2, out_data2;
    logic [0:0]       wb_addr2, out_idx2;
    logic             n_en2, out_valid2, busy2, done2;

    logic [WIDTH-1:0] dp0, dp1, dp2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    neuron_layer_sched #(.WIDTH(WIDTH), .N_NEURON(4), .IDX_W(2), .LAT(2)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start),
        .a_1(a_1), .a_2(a_2), .a_3(a_3),
        .n_a_1(n_a_1), .n_a_2(n_a_2), .n_a_3(n_a_3),
        .wb_addr(wb_addr), .n_en(n_en), .n_y(n_y),
        .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data),
        .busy(busy), .done(done)
    );

    neuron_layer_sched #(.WIDTH(WIDTH), .N_NEURON(1), .IDX_W(1), .LAT(1)) dut2 (
        .clk(clk), .rst(rst), .en(en), .start(start2),
        .a_1(a_1), .a_2(a_2), .a_3(a_3),
        .n_a_1(n2_a_1), .n_a_2(n2_a_2), .n_a_3(n2_a_3),
        .wb_addr(wb_addr2), .n_en(n_en2), .n_y(n_y2),
        .out_valid(out_valid2), .out_idx(out_idx2), .out_data(out_data2),
        .busy(busy2), .done(done2)
    );

    // Datapath models: y = 0x0010_0000 + wb_addr delayed by LAT enabled cycles.
    always @(posedge clk) begin
        if (n_en) begin
            dp0 <= C_Y0 + 32'(wb_addr);
            dp1 <= dp0;
        end
        if (n_en2) begin
            dp2 <= C_Y0 + 32'(wb_addr2);
        end
    end
    assign n_y  = dp1;
    assign n_y2 = dp2;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; start = 1'b0; start2 = 1'b0;
        a_1 = '0; a_2 = '0; a_3 = '0;
        tick;
        tick;
        en = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags busy=%b done=%b out_valid=%b required 0/0/0", busy, done, out_valid);
        end
        n_checks++;
        if (out_idx !== 2'd0 || wb_addr !== 2'd0 || n_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idx out_idx=%0d wb_addr=%0d n_en=%b required 0/0/0", out_idx, wb_addr, n_en);
        end
        n_checks++;
        if (n_a_1 !== '0 || n_a_2 !== '0 || n_a_3 !== '0) begin
            n_fail++;
            $display("FAIL reset_na n_a=%h/%h/%h required 0", n_a_1, n_a_2, n_a_3);
        end
        n_checks++;
        if (busy2 !== 1'b0 || done2 !== 1'b0 || out_valid2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dut2 busy=%b done=%b out_valid=%b required 0/0/0", busy2, done2, out_valid2);
        end
        rst = 1'b0;
        tick;
    endtask

    // Start at the next edge (S), then check cycles S+1..S+9 with en held high.
    task automatic test_basic(input string tag);
        logic       ev;
        logic [1:0] ek;
        en = 1'b1; start = 1'b1;
        a_1 = C_A1; a_2 = C_A2; a_3 = C_A3;
        tick;
        start = 1'b0;
        a_1 = 32'h1234_5678; a_2 = 32'h0BAD_F00D; a_3 = 32'h7777_0000;
        for (int t = 1; t <= 9; t++) begin
            #1;
            ev = (t >= 3 && t <= 6);
            ek = 2'(t - 3);
            n_checks++;
            if (out_valid !== ev) begin
                n_fail++;
                $display("FAIL %s_valid t=%0d got %b required %b", tag, t, out_valid, ev);
            end
            if (ev) begin
                n_checks++;
                if (out_idx !== ek || out_data !== C_Y0 + 32'(ek)) begin
                    n_fail++;
                    $display("FAIL %s_result t=%0d idx=%0d data=%h required idx=%0d data=%h",
                             tag, t, out_idx, out_data, ek, C_Y0 + 32'(ek));
                end
            end
            if (t <= 4) begin
                n_checks++;
                if (wb_addr !== 2'(t - 1) || n_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_issue t=%0d wb_addr=%0d n_en=%b required %0d/1", tag, t, wb_addr, n_en, t - 1);
                end
            end
            n_checks++;
            if (done !== (t == 7) || busy !== (t <= 6)) begin
                n_fail++;
                $display("FAIL %s_ctrl t=%0d done=%b busy=%b required %b/%b", tag, t, done, busy, t == 7, t <= 6);
            end
            n_checks++;
            if (n_a_1 !== C_A1 || n_a_2 !== C_A2 || n_a_3 !== C_A3) begin
                n_fail++;
                $display("FAIL %s_na t=%0d n_a=%h/%h/%h required %h/%h/%h", tag, t, n_a_1, n_a_2, n_a_3, C_A1, C_A2, C_A3);
            end
            tick;
        end
    endtask

    // en low at S+2..S+4 (ISSUE) and S+8..S+9 (DRAIN): results at 6,7,10,11, done at 12.
    task automatic test_stall;
        int         vt [4] = '{6, 7, 10, 11};
        int         pulses;
        logic       ev;
        logic [1:0] ek;
        pulses = 0;
        en = 1'b1; start = 1'b1;
        a_1 = C_A1; a_2 = C_A2; a_3 = C_A3;
        tick;
        start = 1'b0;
        for (int t = 1; t <= 14; t++) begin
            en = !(t inside {2, 3, 4, 8, 9});
            #1;
            ev = 1'b0;
            ek = 2'd0;
            for (int k = 0; k < 4; k++) begin
                if (vt[k] == t) begin
                    ev = 1'b1;
                    ek = 2'(k);
                end
            end
            if (out_valid === 1'b1) pulses++;
            n_checks++;
            if (out_valid !== ev) begin
                n_fail++;
                $display("FAIL stall_valid t=%0d en=%b got %b required %b", t, en, out_valid, ev);
            end
            if (ev) begin
                n_checks++;
                if (out_idx !== ek || out_data !== C_Y0 + 32'(ek)) begin
                    n_fail++;
                    $display("FAIL stall_result t=%0d idx=%0d data=%h required idx=%0d data=%h",
                             t, out_idx, out_data, ek, C_Y0 + 32'(ek));
                end
            end
            n_checks++;
            if (done !== (t == 12) || busy !== (t <= 11)) begin
                n_fail++;
                $display("FAIL stall_ctrl t=%0d done=%b busy=%b required %b/%b", t, done, busy, t == 12, t <= 11);
            end
            tick;
        end
        en = 1'b1;
        n_checks++;
        if (pulses != 4) begin
            n_fail++;
            $display("FAIL stall_count got %0d pulses required 4", pulses);
        end
    endtask

    // start held through a whole run (including the done edge) with new a_* values.
    task automatic test_busy_start;
        en = 1'b1; start = 1'b1;
        a_1 = C_A1; a_2 = C_A2; a_3 = C_A3;
        tick;
        a_1 = 32'hAAAA_AAAA; a_2 = 32'h5555_5555; a_3 = 32'h0F0F_0F0F;
        for (int t = 1; t <= 7; t++) begin
            #1;
            n_checks++;
            if (out_valid !== (t >= 3 && t <= 6) || done !== (t == 7) || busy !== (t <= 6)) begin
                n_fail++;
                $display("FAIL busy_start_ctrl t=%0d valid=%b done=%b busy=%b", t, out_valid, done, busy);
            end
            n_checks++;
            if (n_a_1 !== C_A1 || n_a_2 !== C_A2 || n_a_3 !== C_A3) begin
                n_fail++;
                $display("FAIL busy_start_na t=%0d n_a=%h/%h/%h required %h/%h/%h", t, n_a_1, n_a_2, n_a_3, C_A1, C_A2, C_A3);
            end
            tick;
        end
        test_basic("second_run");
    endtask

    task automatic test_reset_midrun;
        en = 1'b1; start = 1'b1;
        a_1 = C_A1; a_2 = C_A2; a_3 = C_A3;
        tick;
        start = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            if (t == 4) rst = 1'b1;
            #1;
            n_checks++;
            if (out_valid !== (t >= 3) || (t >= 3 && out_idx !== 2'(t - 3))) begin
                n_fail++;
                $display("FAIL midrun_pre t=%0d valid=%b idx=%0d required %b/%0d", t, out_valid, out_idx, t >= 3, t - 3);
            end
            tick;
        end
        rst = 1'b0;
        for (int t = 5; t <= 9; t++) begin
            #1;
            n_checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL midrun_post t=%0d busy=%b valid=%b done=%b required 0/0/0", t, busy, out_valid, done);
            end
            tick;
        end
        test_basic("after_reset");
    endtask

    // N_NEURON=1, LAT=1: single result idx 0 at S+2, done at S+3.
    task automatic test_edge_single;
        en = 1'b1; start = 1'b0; start2 = 1'b1;
        a_1 = C_A1; a_2 = C_A2; a_3 = C_A3;
        tick;
        start2 = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            #1;
            n_checks++;
            if (out_valid2 !== (t == 2)) begin
                n_fail++;
                $display("FAIL single_valid t=%0d got %b required %b", t, out_valid2, t == 2);
            end
            if (t == 2) begin
                n_checks++;
                if (out_idx2 !== 1'b0 || out_data2 !== C_Y0) begin
                    n_fail++;
                    $display("FAIL single_result idx=%0d data=%h required 0/%h", out_idx2, out_data2, C_Y0);
                end
            end
            n_checks++;
            if (done2 !== (t == 3) || busy2 !== (t <= 2)) begin
                n_fail++;
                $display("FAIL single_ctrl t=%0d done=%b busy=%b required %b/%b", t, done2, busy2, t == 3, t <= 2);
            end
            tick;
        end
    endtask

    initial begin
        test_reset;
        test_basic("basic");
        test_stall;
        test_busy_start;
        test_reset_midrun;
        test_edge_single;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/neuron_layer_sched.md
Name: neuron_layer_sched

Overview:
- Time-multiplexes one shared 3-input Q8.24 neuron datapath (multipliers, pipeline registers, sigmoid) across the N_NEURON neurons of one layer.
- On each start it latches the layer inputs and issues one neuron index per enabled cycle as the weight/bias bank address.
- It tracks datapath latency and emits each neuron's activation tagged with its index, then pulses done.
- Sits between the layer input buffer, the weight/bias bank and the next layer's activation buffer.

Parameters:
- WIDTH, 32, data width of activations, weights and results (Q8.24).
- N_NEURON, 4, number of neurons in the layer (>=1).
- IDX_W, 2, index width; must satisfy 2**IDX_W >= N_NEURON.
- LAT, 2, enabled cycles from index issue to a valid n_y (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global clock enable; when low all internal state holds.
- start  input  1  request to run the layer; accepted only in IDLE with en=1.
- a_1, a_2, a_3  input  WIDTH each  layer inputs, sampled on accepted start.
- n_a_1, n_a_2, n_a_3  output  WIDTH each  latched inputs driven to the datapath.
- wb_addr  output  IDX_W  neuron index into the weight/bias bank; the bank read is combinational.
- n_en  output  1  datapath enable.
- n_y  input  WIDTH  datapath result.
- out_valid  output  1  out_data/out_idx valid this cycle.
- out_idx  output  IDX_W  neuron index of out_data.
- out_data  output  WIDTH  activation (n_y passed through).
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse after the last result.

Behaviour:
- Reset (rst=1 at an edge, regardless of en):
  - State goes to IDLE.
  - issue_cnt=0; valid/index shift pipe cleared.
  - n_a_* = 0, busy=0, done=0, out_valid=0, out_idx=0, wb_addr=0.
- Shift pipe:
  - LAT stages, each holding {vld, idx}.
  - Shifts only when en=1. Stage 0 is loaded with {issuing, wb_addr}.
- n_en = en whenever the state is not IDLE; 0 in IDLE.
  - The datapath therefore freezes exactly with the scheduler.
- States and transitions (all transitions require en=1; with en=0 everything holds):
  - IDLE: on start, latch a_* into n_a_*, set busy=1, clear issue_cnt, go to ISSUE.
  - ISSUE: wb_addr = issue_cnt and the issuing flag is 1. issue_cnt increments each cycle. After index N_NEURON-1 is issued, go to DRAIN.
  - DRAIN: issuing flag is 0. Wait until the pipe holds no vld bits, then go to DONE.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- Output:
  - out_valid = en AND tail-stage vld.
  - out_idx = tail idx; out_data = n_y.
  - out_valid is forced 0 while en=0, so a stalled result is never reported twice.
- Timing with en held high:
  - Index k is issued at cycle S+1+k, where S is the start-accept cycle.
  - Result k has out_valid at S+1+k+LAT.
  - done is asserted at S+N_NEURON+LAT+1.
  - Results are in ascending index order, one per cycle, with no gaps.
- start handling:
  - start while busy is ignored, with no queueing.
  - start on the same edge as done is ignored; a new start is accepted the cycle after DONE.
- Stability: n_a_* hold their value for the whole run and after it, until the next accepted start.
- Index arithmetic:
  - issue_cnt is IDX_W+1 bits wide, so N_NEURON = 2**IDX_W terminates without wrap.
  - wb_addr uses the low IDX_W bits.
- N_NEURON=1: one ISSUE cycle, then DRAIN.
- Reset mid-run: run aborted, no done pulse, in-flight results discarded (pipe cleared). The next start runs normally.

Test Plan:
- Bench model: datapath is an LAT-stage delay of y = 0x0010_0000 + wb_addr, with en-gated stages.
- Basic run: rst, then start with a_1/a_2/a_3 = 0x0100_0000/0x0080_0000/0xFF00_0000, en=1, N_NEURON=4, LAT=2.
  - out_valid at S+3..S+6 with idx 0..3 and data 0x0010_0000..0x0010_0003.
  - done at S+7; busy high S+1..S+6.
  - n_a_* hold the start values throughout.
- Stall: same run with en=0 for 3 cycles during ISSUE and 2 cycles during DRAIN.
  - Exactly 4 out_valid pulses, idx 0..3 in order, each with correct data.
  - No out_valid while en=0; done delayed by exactly 5 cycles.
- Busy start: assert start on every cycle of a run.
  - Only one run occurs; n_a_* unchanged by the later a_* values.
  - A start in the cycle after done begins a second identical run.
- Reset mid-run: rst=1 at S+4 (two results emitted).
  - Next cycle: busy=0, out_valid=0, no done pulse.
  - A subsequent start yields the full 4 results.
- Edge configuration: N_NEURON=1, LAT=1, and N_NEURON=4 with IDX_W=2.
  - Single result idx 0 at S+2, done at S+3.
  - Full-range case issues idx 3 and terminates with no wrap to idx 0.
